// File: rtl/asrm_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, FSM state encoding and the divisor reset value.
package asrm_uart_tx_pkg;

  localparam int OFF_DATA   = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_DIV    = 2;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;

  localparam int DIV_RESET = 868;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/asrm_uart_tx_if.sv
// CPU system-bus slice seen by the UART: address, write data, write strobe
// and the registered read data returned to the core.
interface asrm_uart_tx_if #(
  parameter int wordsize = 16
);
  logic [wordsize-1:0] addr;
  logic [wordsize-1:0] wdata;
  logic                write_en;
  logic [wordsize-1:0] rdata;

  modport master (output addr, output wdata, output write_en, input rdata);
  modport slave  (input addr, input wdata, input write_en, output rdata);
endinterface

// File: rtl/asrm_fifo.sv
// Synchronous FIFO with registered read data. A push while full is still
// accepted when a pop frees a slot on the same edge.
module asrm_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(depth);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers and occupancy; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage write and registered read on pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
    if (pop_ok)  dout <= mem[rd_ptr];
  end

endmodule

// File: rtl/asrm_uart_tx.sv
// Memory-mapped 8N1 transmitter: DATA/STATUS/DIV registers on the CPU bus,
// a byte FIFO and a start/data/stop shifting FSM with programmable divisor.
module asrm_uart_tx
  import asrm_uart_tx_pkg::*;
#(
  parameter int                  wordsize   = 16,
  parameter logic [wordsize-1:0] base_addr  = 16'hFF00,
  parameter int                  clk_div    = DIV_RESET,
  parameter int                  fifo_depth = 8
) (
  input  logic              clk,
  input  logic              reset,
  asrm_uart_tx_if.slave     bus,
  output logic              tx,
  output logic              busy
);
  localparam logic [wordsize-1:0] ONE         = 1;
  localparam logic [wordsize-1:0] ADDR_DATA   = base_addr + wordsize'(OFF_DATA);
  localparam logic [wordsize-1:0] ADDR_STATUS = base_addr + wordsize'(OFF_STATUS);
  localparam logic [wordsize-1:0] ADDR_DIV    = base_addr + wordsize'(OFF_DIV);

  // A divisor of zero would never let the baud counter expire; run it as 1.
  function automatic logic [wordsize-1:0] clamp_div(input logic [wordsize-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  logic                hit_data, hit_status, hit_div;
  logic                prev_we;
  logic [wordsize-1:0] prev_addr;
  logic                wr_new;
  logic [wordsize-1:0] div_reg;
  logic                overflow;
  logic [wordsize-1:0] status;
  logic [wordsize-1:0] rd_mux;
  logic                push, pop, fifo_full, fifo_empty;
  logic [7:0]          fifo_dout;

  tx_state_e           state, state_n;
  logic [wordsize-1:0] baud_cnt, baud_n;
  logic [wordsize-1:0] div_act, div_act_n;
  logic [2:0]          bit_cnt, bit_n;
  logic                tx_n;

  assign hit_data   = (bus.addr == ADDR_DATA);
  assign hit_status = (bus.addr == ADDR_STATUS);
  assign hit_div    = (bus.addr == ADDR_DIV);
  assign wr_new     = bus.write_en && (!prev_we || (bus.addr != prev_addr));
  assign push       = wr_new && hit_data;
  assign busy       = !fifo_empty || (state != S_IDLE);

  asrm_fifo #(.width(8), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Remember last cycle's strobe and address so a held write acts only once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_we   <= 1'b0;
      prev_addr <= '0;
    end else begin
      prev_we   <= bus.write_en;
      prev_addr <= bus.addr;
    end
  end

  // Divisor register and sticky overflow flag (write-1-to-clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_reg  <= wordsize'(clk_div);
      overflow <= 1'b0;
    end else begin
      if (wr_new && hit_div) div_reg <= bus.wdata;
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (wr_new && hit_status && bus.wdata[ST_OVF])
        overflow <= 1'b0;
    end
  end

  // Read mux: STATUS on DATA/STATUS, DIV on DIV, zero everywhere else.
  always_comb begin
    status             = '0;
    status[ST_EMPTY]   = fifo_empty;
    status[ST_FULL]    = fifo_full;
    status[ST_ACTIVE]  = (state != S_IDLE);
    status[ST_OVF]     = overflow;
    rd_mux             = '0;
    if (hit_data || hit_status) rd_mux = status;
    else if (hit_div)           rd_mux = div_reg;
  end

  // Registered read data so it can be ORed onto the shared bus.
  always_ff @(posedge clk) begin
    if (!reset) bus.rdata <= '0;
    else        bus.rdata <= rd_mux;
  end

  // Transmit FSM state, counters and registered serial output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      div_act  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      div_act  <= div_act_n;
      tx       <= tx_n;
    end
  end

  // Next-state logic; the line level is computed from the next state so tx
  // changes on the same edge as the state it belongs to.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_cnt;
    div_act_n = div_act;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          div_act_n = clamp_div(div_reg);
          baud_n    = clamp_div(div_reg) - ONE;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (baud_cnt == '0) begin
          baud_n  = div_act - ONE;
          bit_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt - ONE;
        end
      end
      S_DATA: begin
        if (baud_cnt == '0) begin
          baud_n = div_act - ONE;
          bit_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end else begin
          baud_n = baud_cnt - ONE;
        end
      end
      S_STOP: begin
        if (baud_cnt == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            div_act_n = clamp_div(div_reg);
            baud_n    = clamp_div(div_reg) - ONE;
            state_n   = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt - ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = fifo_dout[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_asrm_uart_tx.sv
// Scoreboard bench for asrm_uart_tx: bytes written to DATA queue an expected
// frame; an independent line monitor decodes tx and checks each frame.
module tb_asrm_uart_tx;
  localparam int          W    = 16;
  localparam logic [15:0] BASE = 16'hFF00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, busy;

  asrm_uart_tx_if #(.wordsize(W)) bus ();

  asrm_uart_tx #(
    .wordsize(W), .base_addr(BASE), .clk_div(868), .fifo_depth(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];
  int     tests = 0;
  int     fails = 0;
  bit     mon_en = 1'b0;
  bit     abort_req = 1'b0;
  int     model_div = 868;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output int acc_cyc);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.write_en = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    bus.write_en = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [15:0] got);
    @(negedge clk);
    bus.addr = a; bus.write_en = 1'b0;
    @(negedge clk);
    got = bus.rdata;
  endtask

  task automatic write_div(input int d);
    int dummy;
    model_div = d;
    bus_write(BASE + 16'd2, 16'(d), dummy);
  endtask

  // Queue the expected frame first, then issue the DATA write.
  task automatic push_byte(input logic [7:0] d, output int acc_cyc);
    frame_t f;
    f.data = d;
    f.div  = (model_div == 0) ? 1 : model_div;
    exp_q.push_back(f);
    bus_write(BASE, {8'h00, d}, acc_cyc);
  endtask

  task automatic wait_idle(input int max_cyc, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy still high after %0d cycles, required low", max_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input int n_before, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (starts.size() > n_before) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL wait_start: no frame within %0d cycles, required one", max_cyc);
    end
  endtask

  // Line monitor: decode each frame from tx and compare with the scoreboard.
  initial begin : monitor
    frame_t     e;
    int         errs;
    int         b;
    bit         abort;
    logic       expb;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (mon_en && !abort_req && tx === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
          while (tx === 1'b0) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          errs = 0; abort = 1'b0; got = 8'h00;
          for (int i = 0; i < 10 * e.div; i++) begin
            if (i > 0) @(negedge clk);
            if (abort_req) begin abort = 1'b1; break; end
            b = i / e.div;
            if (b == 0)      expb = 1'b0;
            else if (b == 9) expb = 1'b1;
            else             expb = e.data[b-1];
            if (tx !== expb) errs++;
            if ((i % e.div) == 0 && b >= 1 && b <= 8) got[b-1] = tx;
          end
          if (!abort) begin
            tests++;
            if (errs != 0) begin
              fails++;
              $display("FAIL frame: got byte %02h (%0d bad cycles), required %02h at div %0d",
                       got, errs, e.data, e.div);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] r;
    int          acc, fall, s0, n, d;

    bus.addr = 16'h0000; bus.wdata = 16'h0000; bus.write_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rdata", bus.rdata, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    read_reg(BASE + 16'd1, r); check("status_after_reset", r, 16'h0001);
    read_reg(BASE + 16'd2, r); check("div_after_reset", r, 868);
    read_reg(BASE, r);         check("data_reads_status", r, 16'h0001);
    read_reg(BASE + 16'd3, r); check("undecoded_offset", r, 0);
    read_reg(16'h1234, r);     check("not_addressed", r, 0);

    // Single frame A5 at div 4: latency, 40-cycle span, busy release.
    write_div(4);
    s0 = starts.size();
    push_byte(8'hA5, acc);
    check("busy_on_push", busy, 1);
    wait_idle(200, fall);
    check("a5_frames", starts.size() - s0, 1);
    if (starts.size() > s0) begin
      check("a5_start_latency", starts[s0] - acc, 1);
      check("a5_busy_span", fall - starts[s0], 40);
    end
    check("a5_drain", exp_q.size(), 0);

    // Held write strobe produces exactly one frame.
    s0 = starts.size();
    begin
      frame_t f;
      f.data = 8'h41; f.div = 4;
      exp_q.push_back(f);
    end
    @(negedge clk);
    bus.addr = BASE; bus.wdata = 16'h0041; bus.write_en = 1'b1;
    repeat (5) @(negedge clk);
    bus.write_en = 1'b0;
    wait_idle(200, fall);
    check("held_write_frames", starts.size() - s0, 1);

    // Nine back-to-back bytes at div 2, tenth overflows and is dropped.
    write_div(2);
    s0 = starts.size();
    for (int k = 0; k < 9; k++) push_byte(8'h10 + 8'(k), acc);
    bus_write(BASE, 16'h00EE, acc);
    read_reg(BASE + 16'd1, r);
    check("overflow_set", r & 16'h0008, 16'h0008);
    bus_write(BASE + 16'd1, 16'h0008, acc);
    read_reg(BASE + 16'd1, r);
    check("overflow_cleared", r & 16'h0008, 0);
    wait_idle(400, fall);
    check("burst_frames", starts.size() - s0, 9);
    if (starts.size() >= s0 + 9)
      for (int k = 0; k < 8; k++)
        check("burst_no_gap", starts[s0+k+1] - starts[s0+k], 20);

    // Divisor change mid-frame only affects the following frame.
    write_div(4);
    s0 = starts.size();
    push_byte(8'h3C, acc);
    wait_start(s0, 50);
    repeat (10) @(negedge clk);
    write_div(8);
    push_byte(8'hC3, acc);
    read_reg(BASE + 16'd2, r);
    check("div_readback", r, 8);
    wait_idle(300, fall);
    check("divchg_frames", starts.size() - s0, 2);
    if (starts.size() >= s0 + 2)
      check("divchg_first_len", starts[s0+1] - starts[s0], 40);

    // Reset in the middle of DATA aborts the frame and flushes the FIFO.
    write_div(4);
    s0 = starts.size();
    push_byte(8'h5A, acc);
    push_byte(8'h66, acc);
    push_byte(8'h77, acc);
    wait_start(s0, 50);
    repeat (12) @(negedge clk);
    abort_req = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_tx", tx, 1);
    reset = 1'b1;
    exp_q.delete();
    model_div = 868;
    read_reg(BASE + 16'd1, r); check("reset_mid_status", r, 16'h0001);
    check("reset_mid_busy", busy, 0);
    read_reg(BASE + 16'd2, r); check("reset_mid_div", r, 868);
    s0 = starts.size();
    repeat (150) @(negedge clk);
    abort_req = 1'b0;
    check("reset_no_frames", starts.size() - s0, 0);

    // Randomized bursts at random small divisors (0 behaves as 1).
    for (int rnd = 0; rnd < 6; rnd++) begin
      d = int'($urandom_range(0, 5));
      write_div(d);
      read_reg(BASE + 16'd2, r);
      check("rand_div_readback", r, 16'(d));
      n = int'($urandom_range(1, 4));
      s0 = starts.size();
      for (int k = 0; k < n; k++) begin
        push_byte(8'($urandom), acc);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(1000, fall);
      check("rand_frames", starts.size() - s0, n);
      check("rand_drain", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/asrm_uart_tx.md
# asrm_uart_tx

Memory-mapped serial transmitter on the CPU system bus, directly downstream of the CPU core: it consumes the core's `addr`/`data_out`/`write_en` and returns read data on the core's `data_in`. Written bytes are queued in a small FIFO and shifted out as 8N1 frames on `tx` at a programmable baud divisor. Read data is zero whenever the block is not addressed, so its output can be ORed onto the shared read bus with other slaves.

## Interface
- `wordsize`, 16: bus data/address width.
- `base_addr`, 16'hFF00: address of register 0; the block decodes `base_addr`..`base_addr+2`.
- `clk_div`, 868: reset value of the baud divisor (clock cycles per bit).
- `fifo_depth`, 8: transmit FIFO entries; power of two, ≥2.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `addr` in wordsize: bus address from the CPU.
- `wdata` in wordsize: bus write data (CPU `data_out`).
- `write_en` in 1: bus write strobe.
- `rdata` out wordsize: read data to CPU `data_in`; 0 when not addressed.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high when the FIFO is non-empty or a frame is in progress.

## Operation
- Register map, offset from `base_addr`:
  - 0 DATA: a write pushes `wdata[7:0]`. A read returns STATUS.
  - 1 STATUS, read-only except bit 3: bit0 fifo_empty, bit1 fifo_full, bit2 tx_active, bit3 overflow (sticky); the upper bits read 0. Writing 1 to bit 3 clears overflow.
  - 2 DIV: read/write divisor, full word.
  - Other offsets in range are not decoded and read 0.
- Write acceptance:
  - The CPU may hold `write_en` for several cycles. A write takes effect once, on the first cycle `write_en` is high with a matching address.
  - It re-arms after `write_en` has been low for one cycle, or after the address changes.
- A push when the FIFO is full drops the byte and sets overflow. A push while full that coincides with a pop is accepted.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, latch DIV into the active divisor, and go to START.
  - START: `tx`=0 for div cycles, then go to DATA.
  - DATA: 8 bits LSB first, div cycles each, then go to STOP.
  - STOP: `tx`=1 for div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Baud counter: loads div−1 and counts down to 0. A DIV value of 0 is treated as 1.
- A DIV write during a frame affects only the next frame.
- The bit counter is 3 bits and wraps from 7 to 0 on exit from DATA.

## Timing
- Reset values: `tx`=1, `rdata`=0, `busy`=0, FIFO empty, overflow=0, DIV=`clk_div`, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame; `tx` returns high on the next edge and the FIFO contents are discarded.
- `rdata` is registered: it is valid the cycle after `addr` is presented and holds while `addr` is stable.
- STATUS reflects FIFO state after the previous edge.
- A write accepted at edge N with the FIFO empty and the FSM in IDLE:
  - the pop happens at edge N+1;
  - `tx` falls after edge N+1;
  - the frame spans exactly 10·div cycles.
- `busy` rises at the push edge and falls on the edge that enters IDLE with the FIFO empty.
- A DIV write at the same edge as an IDLE→START transition is not used for that frame.

## Structure
- Shared header `asrm_uart.vh`:
  - register offsets (DATA=0, STATUS=1, DIV=2);
  - STATUS bit positions;
  - FSM state encodings (IDLE, START, DATA, STOP);
  - reset value of DIV.
- Sub-module `asrm_fifo`:
  - synchronous FIFO with parameters width and depth;
  - push/pop, full/empty, read data registered on pop;
  - simultaneous push/pop supported when full or empty.
- The top level contains address decode, write edge qualification, the register file, and the transmit FSM.

## Test plan
- Reset, then read STATUS → `rdata`=16'h0001, `tx`=1, `busy`=0; read DIV → 868.
- Write DIV=4, then DATA=8'hA5 → `tx` is low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high; 40 cycles total; `busy` falls after the stop bit.
- Hold `write_en` high for 5 cycles on DATA with 8'h41 → exactly one frame is sent.
- With DIV=2, write 9 bytes back-to-back (fifo_depth 8, one byte already popped) → no overflow and 9 contiguous frames with no idle gap. A 10th write while full → overflow bit=1 and that byte is never sent. Write 16'h0008 to STATUS → overflow cleared.
- Write DIV=8 mid-frame with DIV=4 → the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
- Assert reset during DATA → `tx`=1 after the next edge, STATUS=16'h0001, and no further frames are sent.
